// File: rtl/stc_aloader_pkg.sv
// Shared definitions for the sparse-tensor-core A-operand loader.
// FSM encodings and counter-width helpers used by the loader and its address generator.
package stc_aloader_pkg;

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [ST_W-1:0] ST_LOAD   = 2'd1;
    localparam logic [ST_W-1:0] ST_FILLED = 2'd2;

    // Bits needed to hold values 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/stc_aloader_addrgen.sv
// Request address generator: running per-array row addresses and request counter.
// Even requests fetch the value row, odd requests the col-index row; both rows advance after the odd one.
module stc_aloader_addrgen
    import stc_aloader_pkg::*;
#(
    parameter int unsigned DW_ADDR = 32,
    parameter int unsigned CNT_W   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [DW_ADDR-1:0] base_data,
    input  logic [DW_ADDR-1:0] base_cidx,
    input  logic [DW_ADDR-1:0] row_stride,
    output logic [DW_ADDR-1:0] req_addr,
    output logic [CNT_W-1:0]   req_cnt
);

    logic [DW_ADDR-1:0] data_addr;
    logic [DW_ADDR-1:0] cidx_addr;
    logic [DW_ADDR-1:0] stride;
    logic [DW_ADDR-1:0] data_addr_inc;
    logic [DW_ADDR-1:0] cidx_addr_inc;

    // Incremental row multiply; wraps modulo 2^DW_ADDR.
    always_comb begin
        data_addr_inc = data_addr + stride;
        cidx_addr_inc = cidx_addr + stride;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_addr <= '0;
            cidx_addr <= '0;
            stride    <= '0;
            req_addr  <= '0;
            req_cnt   <= '0;
        end else if (load) begin
            data_addr <= base_data;
            cidx_addr <= base_cidx;
            stride    <= row_stride;
            req_addr  <= base_data;
            req_cnt   <= '0;
        end else if (step) begin
            req_cnt <= req_cnt + CNT_W'(1);
            if (!req_cnt[0]) begin
                req_addr <= cidx_addr;
            end else begin
                data_addr <= data_addr_inc;
                cidx_addr <= cidx_addr_inc;
                req_addr  <= data_addr_inc;
            end
        end
    end

endmodule

// File: rtl/stc_aloader.sv
// Writer side of the sparse-tensor-core A-operand buffer.
// Fetches an M-row compressed tile (value beat + col-index beat per row) and writes it into the buffer.
module stc_aloader
    import stc_aloader_pkg::*;
#(
    parameter int unsigned M       = 16,
    parameter int unsigned DW_MEM  = 512,
    parameter int unsigned DW_COL  = 4,
    parameter int unsigned DW_ADDR = 32,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DW_ADDR-1:0] base_data,
    input  logic [DW_ADDR-1:0] base_cidx,
    input  logic [DW_ADDR-1:0] row_stride,
    output logic               busy,
    output logic               done,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [DW_ADDR-1:0] mem_req_addr,
    input  logic               mem_rsp_valid,
    output logic               mem_rsp_ready,
    input  logic [DW_MEM-1:0]  mem_rsp_data,
    output logic               write_data_en,
    output logic               write_cidx_en,
    output logic [DW_COL-1:0]  idx,
    output logic [DW_MEM-1:0]  A_data_input,
    output logic [DW_MEM-1:0]  A_colidx_input,
    output logic               tile_valid,
    input  logic               tile_consumed
);

    localparam int unsigned BEATS = 2 * M;
    localparam int unsigned CNT_W = cnt_width(BEATS);
    localparam int unsigned OUT_W = cnt_width(MAX_OUT);

    logic [ST_W-1:0]  state;
    logic [ST_W-1:0]  state_nxt;
    logic             load;
    logic             req_fire;
    logic             rsp_fire;
    logic [CNT_W-1:0] req_cnt;
    logic [CNT_W-1:0] req_cnt_nxt;
    logic [CNT_W-1:0] rsp_cnt;
    logic [CNT_W-1:0] rsp_cnt_nxt;
    logic [OUT_W-1:0] outst;
    logic [OUT_W-1:0] outst_nxt;
    logic             req_valid_nxt;
    logic             done_nxt;

    always_comb begin
        req_fire = mem_req_valid & mem_req_ready;
        rsp_fire = mem_rsp_valid & mem_rsp_ready;
    end

    stc_aloader_addrgen #(
        .DW_ADDR (DW_ADDR),
        .CNT_W   (CNT_W)
    ) u_addrgen (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .step       (req_fire),
        .base_data  (base_data),
        .base_cidx  (base_cidx),
        .row_stride (row_stride),
        .req_addr   (mem_req_addr),
        .req_cnt    (req_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus next-cycle counter values that feed the registered outputs.
    always_comb begin
        state_nxt     = state;
        load          = 1'b0;
        done_nxt      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_LOAD;
                    load      = 1'b1;
                end
            end
            ST_LOAD: begin
                if (rsp_cnt == CNT_W'(BEATS)) begin
                    state_nxt = ST_FILLED;
                end
            end
            ST_FILLED: begin
                if (tile_consumed) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        req_cnt_nxt = load ? '0 : req_cnt + CNT_W'(req_fire);
        rsp_cnt_nxt = load ? '0 : rsp_cnt + CNT_W'(rsp_fire);
        outst_nxt   = load ? '0 : outst + OUT_W'(req_fire) - OUT_W'(rsp_fire);

        // Built from next-cycle values so valid can only fall after a handshake.
        req_valid_nxt = (state_nxt == ST_LOAD) &&
                        (req_cnt_nxt < CNT_W'(BEATS)) &&
                        (outst_nxt < OUT_W'(MAX_OUT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_cnt       <= '0;
            outst         <= '0;
            mem_req_valid <= 1'b0;
            mem_rsp_ready <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            tile_valid    <= 1'b0;
        end else begin
            rsp_cnt       <= rsp_cnt_nxt;
            outst         <= outst_nxt;
            mem_req_valid <= req_valid_nxt;
            mem_rsp_ready <= (state_nxt == ST_LOAD);
            busy          <= (state_nxt != ST_IDLE);
            done          <= done_nxt;
            tile_valid    <= (state_nxt == ST_FILLED);
        end
    end

    // Buffer write port: beat k lands one cycle after its handshake, row k>>1.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_data_en  <= 1'b0;
            write_cidx_en  <= 1'b0;
            idx            <= '0;
            A_data_input   <= '0;
            A_colidx_input <= '0;
        end else begin
            write_data_en <= rsp_fire & ~rsp_cnt[0];
            write_cidx_en <= rsp_fire &  rsp_cnt[0];
            if (rsp_fire) begin
                idx <= DW_COL'(rsp_cnt >> 1);
                if (!rsp_cnt[0]) begin
                    A_data_input <= mem_rsp_data;
                end else begin
                    A_colidx_input <= mem_rsp_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_stc_aloader.sv
// Directed bench for stc_aloader: table of tile-load scenarios plus a mid-load reset sequence.
module tb_stc_aloader;

    localparam int unsigned M       = 16;
    localparam int unsigned DW_MEM  = 512;
    localparam int unsigned DW_COL  = 4;
    localparam int unsigned DW_ADDR = 32;
    localparam int unsigned MAX_OUT = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [DW_ADDR-1:0] base_data;
    logic [DW_ADDR-1:0] base_cidx;
    logic [DW_ADDR-1:0] row_stride;
    logic               busy;
    logic               done;
    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [DW_ADDR-1:0] mem_req_addr;
    logic               mem_rsp_valid;
    logic               mem_rsp_ready;
    logic [DW_MEM-1:0]  mem_rsp_data;
    logic               write_data_en;
    logic               write_cidx_en;
    logic [DW_COL-1:0]  idx;
    logic [DW_MEM-1:0]  A_data_input;
    logic [DW_MEM-1:0]  A_colidx_input;
    logic               tile_valid;
    logic               tile_consumed;

    always #5 clk = ~clk;

    stc_aloader #(
        .M(M), .DW_MEM(DW_MEM), .DW_COL(DW_COL), .DW_ADDR(DW_ADDR), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .base_data(base_data), .base_cidx(base_cidx), .row_stride(row_stride),
        .busy(busy), .done(done),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
        .write_data_en(write_data_en), .write_cidx_en(write_cidx_en), .idx(idx),
        .A_data_input(A_data_input), .A_colidx_input(A_colidx_input),
        .tile_valid(tile_valid), .tile_consumed(tile_consumed)
    );

    // One scenario: bases, ready pattern, latency, injection flag, hand-computed addresses
    // of request 2 (row 1 data), request 30 (row 15 data) and request 31 (row 15 cidx).
    typedef struct {
        logic [31:0] bd;
        logic [31:0] bc;
        logic [31:0] st;
        int          rmode;
        int          lat;
        bit          inj;
        logic [31:0] exp_a2;
        logic [31:0] exp_last_d;
        logic [31:0] exp_last_c;
    } cfg_t;

    typedef struct {
        logic [31:0] addr;
        int          rdy;
    } req_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          nreq, nwd, nwc, rsp_k, last_strobe_cyc;
    req_t        q[$];
    logic [31:0] req_addrs[$];
    cfg_t        cur;
    logic        prev_v, prev_f, exp_pend;
    logic [31:0] prev_a, exp_addr;
    int          exp_k;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DW_MEM-1:0] beat(input logic [31:0] a);
        return {16{a}};
    endfunction

    function automatic logic [31:0] exp_req_addr(input int k);
        logic [63:0] p;
        p = 64'(k / 2) * 64'(cur.st);
        return ((k % 2 == 0) ? cur.bd : cur.bc) + p[31:0];
    endfunction

    // One cycle at the falling edge: check write port/stall rules, drive memory, log handshakes.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (exp_pend) begin
            chk("strobe_data", 64'(write_data_en), 64'(exp_k % 2 == 0));
            chk("strobe_cidx", 64'(write_cidx_en), 64'(exp_k % 2 == 1));
            chk("idx", 64'(idx), 64'(exp_k / 2));
            if (exp_k % 2 == 0) chk("wdata_match", 64'(A_data_input == beat(exp_addr)), 64'd1);
            else                chk("wcidx_match", 64'(A_colidx_input == beat(exp_addr)), 64'd1);
            if (write_data_en) nwd++;
            if (write_cidx_en) nwc++;
            last_strobe_cyc = cyc;
        end else begin
            chk("no_strobe", 64'({write_data_en, write_cidx_en}), 64'd0);
        end
        exp_pend = 1'b0;
        if (prev_v && !prev_f) begin
            chk("stall_valid", 64'(mem_req_valid), 64'd1);
            chk("stall_addr", 64'(mem_req_addr), 64'(prev_a));
        end
        chk("done_tv_excl", 64'(done & tile_valid), 64'd0);

        mem_req_ready = (cur.rmode == 0) ? 1'b1 : 1'(cyc % 2);
        if (q.size() > 0 && q[0].rdy <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = beat(q[0].addr);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
        prev_v = mem_req_valid;
        prev_a = mem_req_addr;
        prev_f = mem_req_valid & mem_req_ready;
        if (mem_rsp_valid && mem_rsp_ready) begin
            exp_pend = 1'b1;
            exp_k    = rsp_k;
            exp_addr = q[0].addr;
            rsp_k++;
            void'(q.pop_front());
        end
        if (prev_f) begin
            chk("req_addr", 64'(mem_req_addr), 64'(exp_req_addr(nreq)));
            req_addrs.push_back(mem_req_addr);
            q.push_back('{mem_req_addr, cyc + cur.lat});
            nreq++;
        end
        chk("outstanding_le_max", 64'(q.size() <= MAX_OUT), 64'd1);
    endtask

    task automatic clear_model();
        q.delete();
        req_addrs.delete();
        nreq = 0; nwd = 0; nwc = 0; rsp_k = 0;
        prev_v = 1'b0; prev_f = 1'b0; exp_pend = 1'b0;
        last_strobe_cyc = 0;
    endtask

    task automatic launch(input cfg_t c);
        cur = c;
        clear_model();
        base_data  = c.bd;
        base_cidx  = c.bc;
        row_stride = c.st;
        start      = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("req_valid_after_start", 64'(mem_req_valid), 64'd1);
    endtask

    task automatic run_tile(input cfg_t c);
        launch(c);
        for (int t = 0; t < 3000 && !tile_valid; t++) begin
            step();
            if (c.inj && t == 5) begin
                start = 1'b1; tile_consumed = 1'b1;
                base_data = 32'hDEAD_0000; base_cidx = 32'hBEEF_0000; row_stride = 32'h4;
            end else begin
                start = 1'b0; tile_consumed = 1'b0;
            end
        end
        chk("tile_valid_reached", 64'(tile_valid), 64'd1);
        chk("num_requests", 64'(nreq), 64'd32);
        chk("num_data_writes", 64'(nwd), 64'd16);
        chk("num_cidx_writes", 64'(nwc), 64'd16);
        chk("tile_valid_latency", 64'(cyc - last_strobe_cyc), 64'd1);
        if (req_addrs.size() == 32) begin
            chk("addr_req2", 64'(req_addrs[2]), 64'(c.exp_a2));
            chk("addr_last_data", 64'(req_addrs[30]), 64'(c.exp_last_d));
            chk("addr_last_cidx", 64'(req_addrs[31]), 64'(c.exp_last_c));
        end else begin
            chk("req_addr_count", 64'(req_addrs.size()), 64'd32);
        end
        chk("busy_filled", 64'(busy), 64'd1);
        chk("req_valid_filled", 64'(mem_req_valid), 64'd0);
        if (c.inj) begin
            start = 1'b1;
            step();
            start = 1'b0;
            chk("start_in_filled_tv", 64'(tile_valid), 64'd1);
            chk("start_in_filled_valid", 64'(mem_req_valid), 64'd0);
            chk("start_in_filled_nreq", 64'(nreq), 64'd32);
        end
        tile_consumed = 1'b1;
        step();
        tile_consumed = 1'b0;
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_released", 64'(busy), 64'd0);
        chk("tile_valid_released", 64'(tile_valid), 64'd0);
        step();
        chk("done_one_cycle", 64'(done), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_req_valid"}, 64'(mem_req_valid), 64'd0);
        chk({tag, "_rsp_ready"}, 64'(mem_rsp_ready), 64'd0);
        chk({tag, "_req_addr"}, 64'(mem_req_addr), 64'd0);
        chk({tag, "_idx"}, 64'(idx), 64'd0);
        chk({tag, "_tile_valid"}, 64'(tile_valid), 64'd0);
        chk({tag, "_data_zero"}, 64'(A_data_input == '0), 64'd1);
        chk({tag, "_cidx_zero"}, 64'(A_colidx_input == '0), 64'd1);
    endtask

    cfg_t tbl[4];

    initial begin
        tbl[0] = '{32'h0000_1000, 32'h0000_8000, 32'h40, 0, 1,  1'b0, 32'h0000_1040, 32'h0000_13C0, 32'h0000_83C0};
        tbl[1] = '{32'h0000_1000, 32'h0000_8000, 32'h40, 1, 10, 1'b0, 32'h0000_1040, 32'h0000_13C0, 32'h0000_83C0};
        tbl[2] = '{32'h0004_0000, 32'h0005_0010, 32'h20, 0, 2,  1'b1, 32'h0004_0020, 32'h0004_01E0, 32'h0005_01F0};
        tbl[3] = '{32'hFFFF_FFC0, 32'h0000_0100, 32'h40, 0, 1,  1'b0, 32'h0000_0000, 32'h0000_0380, 32'h0000_04C0};

        cur = tbl[0];
        clear_model();
        reset = 1'b1; start = 1'b0; tile_consumed = 1'b0;
        base_data = '0; base_cidx = '0; row_stride = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        step();
        step();
        chk_all_zero("reset");
        reset = 1'b0;
        step();

        for (int i = 0; i < 4; i++) begin
            run_tile(tbl[i]);
            step();
        end

        // Abort a load after 7 responses, then reload with fresh bases.
        launch(tbl[1]);
        for (int t = 0; t < 500 && rsp_k < 7; t++) step();
        chk("rsp_before_reset", 64'(rsp_k), 64'd7);
        step();
        reset = 1'b1;
        clear_model();
        step();
        chk_all_zero("midreset");
        reset = 1'b0;
        step();
        chk("idle_after_reset_busy", 64'(busy), 64'd0);
        run_tile('{32'h0000_2000, 32'h0000_9000, 32'h80, 0, 3, 1'b0,
                   32'h0000_2080, 32'h0000_2780, 32'h0000_9780});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
